id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the five-stage RV32I pipeline. It captures decoded control bits, operands and register indices from the decode stage. It inserts a bubble on a load-use hazard or on an EX-stage redirect (flush), and drives the stall request back to PC/IF-ID. It keeps a saturating count of inserted bubbles for performance debug.

## Interface
- XLEN, default 32: datapath width.
- CNT_W, default 16: bubble counter width.

- clk  in  1: rising-edge clock.
- rst  in  1: synchronous, active-high reset.
- id_valid  in  1: decode slot holds a real instruction.
- id_opcode  in  7: instruction opcode, used for hazard-operand qualification.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch, id_jump  in  1 each: decoded control bits.
- id_alu_op  in  2: decoded ALU class.
- id_funct3  in  3; id_funct7  in  7: passed through for ALU control.
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN: operand fields.
- id_rs1, id_rs2, id_rd  in  5: register indices.
- flush  in  1: EX redirect (taken branch/jump). Kill the instruction entering EX.
- ex_* outputs: registered copies of every id_* input above except id_opcode, same widths, plus ex_valid (1).
- hazard_stall  out  1: combinational. Hold PC and IF/ID this cycle.
- bubble_count  out  CNT_W: saturating count of bubbles inserted.

## Operation
- Operand use:
  - use_rs1 = id_opcode not in {0110111 LUI, 1101111 JAL}.
  - use_rs2 = id_opcode in {0110011, 0100011, 1100011}.
- Load-use hazard:
  - Asserted when ex_valid & ex_mem_read & ex_rd != 0 & id_valid.
  - And additionally (use_rs1 & id_rs1 == ex_rd) | (use_rs2 & id_rs2 == ex_rd).
  - hazard_stall = load-use hazard & ~flush.
- Per-edge action, priority order:
  1. rst: all ex_* outputs = 0, bubble_count = 0.
  2. flush: load bubble.
  3. hazard_stall: load bubble. The decode instruction stays in IF/ID, which is held externally.
  4. Otherwise: load all id_* fields, ex_valid = id_valid.
- Bubble definition:
  - ex_valid and all control bits = 0, ex_alu_op = 00.
  - All data/index fields = 0, so ex_rd = x0 and no spurious forwarding match occurs.
- bubble_count increments by 1 on each bubble load from rule 2 or 3, and saturates at 2^CNT_W−1.
- id_valid = 0 with no flush/hazard loads a bubble-equivalent slot but does not count as a bubble.

## Timing
- Latency: 1 cycle, id_* to ex_*.
- hazard_stall is same-cycle combinational from ex_* registers and id_* inputs. No path exists from flush back through the ex_* registers.
- A load followed by a dependent instruction gives exactly one stall cycle. In the next cycle EX holds a bubble, so hazard_stall deasserts and the dependent instruction advances.
- flush and hazard together: flush wins, hazard_stall = 0 (the dependent instruction is being killed anyway), and the count increments by 1, not 2.
- rd = x0 loads never stall.
- rst mid-stall: the next cycle has ex_valid = 0, hazard_stall = 0 and bubble_count = 0.

## Structure
- Shared package rv_pkg holds:
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI;
  - ALU_OP_* 2-bit encodings;
  - a packed ctrl_t struct of the eight control bits.
- One sub-module: load_use_detect, a pure combinational hazard comparator, so it can be reused by an operand-forwarding unit.
- The pipeline register and counter stay in id_ex_stage.

## Test plan
- Pass-through:
  - Stimulus: ADD, id_rs1 = 1, id_rs2 = 2, id_rd = 3, no load in EX.
  - Response: the next cycle ex_rd = 3, ex_reg_write = 1, ex_alu_op = 00, hazard_stall = 0.
- Load-use:
  - Stimulus: LW x5 in EX, ADD x6,x5,x7 in ID.
  - Response: hazard_stall = 1 for one cycle. The next cycle EX is a bubble (ex_valid = 0), bubble_count = 1. The following cycle ex_rd = 6.
- False-dependency filter:
  - Case A: LW x5 in EX, ADDI x6,x1,… in ID with id_rs2 = 5. Required: hazard_stall = 0.
  - Case B: LW x0 in EX, dependent ADD in ID. Required: hazard_stall = 0.
- Flush priority:
  - Stimulus: flush = 1 and load-use condition true in the same cycle.
  - Response: hazard_stall = 0, the next cycle ex_valid = 0, bubble_count +1 only.
- Saturation:
  - Stimulus: CNT_W = 4, 20 consecutive flushes.
  - Response: bubble_count = 15 and holds.
- Reset mid-stall:
  - Stimulus: assert rst while hazard_stall = 1.
  - Response: the next cycle all ex_* = 0, hazard_stall = 0, bubble_count = 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants, ALU class encodings and the control-bit bundle
// used by the pipeline stage registers.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_OP_IMM    = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

    // LUI and JAL carry no rs1 field; only R/store/branch formats read rs2.
    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decoded fields in, registered EX copies out,
// plus the flush request and stall/bubble status.
interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic            id_valid;
    logic [6:0]      id_opcode;
    logic            id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic            id_alu_src, id_branch, id_jump;
    logic [1:0]      id_alu_op;
    logic [2:0]      id_funct3;
    logic [6:0]      id_funct7;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            flush;

    logic            ex_valid;
    logic            ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic            ex_alu_src, ex_branch, ex_jump;
    logic [1:0]      ex_alu_op;
    logic [2:0]      ex_funct3;
    logic [6:0]      ex_funct7;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic            hazard_stall;
    logic [CNT_W-1:0] bubble_count;

    modport master (
        output id_valid, id_opcode, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               id_alu_src, id_branch, id_jump, id_alu_op, id_funct3, id_funct7,
               id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, flush,
        input  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_alu_src, ex_branch, ex_jump, ex_alu_op, ex_funct3, ex_funct7,
               ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
               hazard_stall, bubble_count
    );

    modport slave (
        input  id_valid, id_opcode, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               id_alu_src, id_branch, id_jump, id_alu_op, id_funct3, id_funct7,
               id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, flush,
        output ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_alu_src, ex_branch, ex_jump, ex_alu_op, ex_funct3, ex_funct7,
               ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
               hazard_stall, bubble_count
    );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a valid load in EX whose rd is read by the
// instruction in ID. Kept standalone so a forwarding unit can share it.
module load_use_detect
    import rv_pkg::*;
(
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use
);
    logic rs1_hit, rs2_hit;

    assign rs1_hit  = uses_rs1(id_opcode) && (id_rs1 == ex_rd);
    assign rs2_hit  = uses_rs2(id_opcode) && (id_rs2 == ex_rd);
    // x0 is never a real producer, so a load to x0 cannot create a dependency.
    assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid
                      && (rs1_hit || rs2_hit);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use/flush bubble insertion and a saturating
// bubble counter.
module id_ex_stage
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);
    ctrl_t            id_ctrl, ex_ctrl;
    logic             ex_valid;
    logic [2:0]       ex_funct3;
    logic [6:0]       ex_funct7;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [CNT_W-1:0] cnt;
    logic             load_use, stall, bubble, load_en;

    assign id_ctrl = '{reg_write: bus.id_reg_write, mem_read: bus.id_mem_read,
                       mem_write: bus.id_mem_write, mem_to_reg: bus.id_mem_to_reg,
                       alu_src: bus.id_alu_src, branch: bus.id_branch,
                       jump: bus.id_jump, alu_op: bus.id_alu_op};

    load_use_detect u_lud (
        .id_valid    (bus.id_valid),
        .id_opcode   (bus.id_opcode),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    // A flushed instruction is being killed anyway, so it must not also stall IF.
    assign stall   = load_use && !bus.flush;
    assign bubble  = bus.flush || stall;
    assign load_en = !bubble && bus.id_valid;

    // Bubbles and empty decode slots both load all-zero, so ex_rd reads as x0.
    always_ff @(posedge clk) begin
        if (rst || !load_en) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_funct3   <= '0;
            ex_funct7   <= '0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
        end else begin
            ex_valid    <= 1'b1;
            ex_ctrl     <= id_ctrl;
            ex_funct3   <= bus.id_funct3;
            ex_funct7   <= bus.id_funct7;
            ex_pc       <= bus.id_pc;
            ex_rs1_data <= bus.id_rs1_data;
            ex_rs2_data <= bus.id_rs2_data;
            ex_imm      <= bus.id_imm;
            ex_rs1      <= bus.id_rs1;
            ex_rs2      <= bus.id_rs2;
            ex_rd       <= bus.id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (bubble && cnt != {CNT_W{1'b1}})
            cnt <= cnt + CNT_W'(1);
    end

    assign bus.ex_valid      = ex_valid;
    assign bus.ex_reg_write  = ex_ctrl.reg_write;
    assign bus.ex_mem_read   = ex_ctrl.mem_read;
    assign bus.ex_mem_write  = ex_ctrl.mem_write;
    assign bus.ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign bus.ex_alu_src    = ex_ctrl.alu_src;
    assign bus.ex_branch     = ex_ctrl.branch;
    assign bus.ex_jump       = ex_ctrl.jump;
    assign bus.ex_alu_op     = ex_ctrl.alu_op;
    assign bus.ex_funct3     = ex_funct3;
    assign bus.ex_funct7     = ex_funct7;
    assign bus.ex_pc         = ex_pc;
    assign bus.ex_rs1_data   = ex_rs1_data;
    assign bus.ex_rs2_data   = ex_rs2_data;
    assign bus.ex_imm        = ex_imm;
    assign bus.ex_rs1        = ex_rs1;
    assign bus.ex_rs2        = ex_rs2;
    assign bus.ex_rd         = ex_rd;
    assign bus.hazard_stall  = stall;
    assign bus.bubble_count  = cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a
// slot-level model of the EX register and bubble counter.
module tb_id_ex_stage;
    import rv_pkg::*;

    localparam int XLEN = 32;
    localparam int CW   = 4;
    localparam int VW   = 1 + 7 + 2 + 3 + 7 + 4*XLEN + 15;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CW)) bus ();

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Whole EX slot flattened so one compare covers every registered field.
    wire [VW-1:0] ex_vec = {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                            bus.ex_mem_to_reg, bus.ex_alu_src, bus.ex_branch, bus.ex_jump,
                            bus.ex_alu_op, bus.ex_funct3, bus.ex_funct7, bus.ex_pc,
                            bus.ex_rs1_data, bus.ex_rs2_data, bus.ex_imm,
                            bus.ex_rs1, bus.ex_rs2, bus.ex_rd};

    // Model: what instruction sits in EX, whether it is a load, and bubbles so far.
    logic [VW-1:0] m_vec;
    bit            m_ld;
    logic [4:0]    m_rd;
    int            m_cnt;

    function automatic logic [VW-1:0] id_vec();
        return {1'b1, bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
                bus.id_mem_to_reg, bus.id_alu_src, bus.id_branch, bus.id_jump,
                bus.id_alu_op, bus.id_funct3, bus.id_funct7, bus.id_pc,
                bus.id_rs1_data, bus.id_rs2_data, bus.id_imm,
                bus.id_rs1, bus.id_rs2, bus.id_rd};
    endfunction

    // Stall when the ID instruction reads a register a load in EX is still fetching.
    function automatic bit exp_stall();
        bit r1, r2;
        r1 = !(bus.id_opcode inside {OP_LUI, OP_JAL});
        r2 = bus.id_opcode inside {OP_R, OP_STORE, OP_BRANCH};
        return !bus.flush && bus.id_valid && m_ld && m_rd != 5'd0 &&
               ((r1 && bus.id_rs1 == m_rd) || (r2 && bus.id_rs2 == m_rd));
    endfunction

    task automatic tick();
        bit b;
        b = bus.flush || exp_stall();
        @(posedge clk);
        if (rst) begin
            m_vec = '0; m_ld = 0; m_rd = '0; m_cnt = 0;
        end else if (b) begin
            m_vec = '0; m_ld = 0; m_rd = '0;
            if (m_cnt < CMAX) m_cnt++;
        end else if (bus.id_valid) begin
            m_vec = id_vec(); m_ld = bus.id_mem_read; m_rd = bus.id_rd;
        end else begin
            m_vec = '0; m_ld = 0; m_rd = '0;
        end
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd);
        bus.id_valid  = 1'b1;
        bus.id_opcode = op;
        {bus.id_reg_write, bus.id_mem_write, bus.id_mem_to_reg, bus.id_alu_src,
         bus.id_branch, bus.id_jump, bus.id_alu_op} = 8'($urandom);
        bus.id_mem_read = (op == OP_LOAD);
        bus.id_funct3   = 3'($urandom);
        bus.id_funct7   = 7'($urandom);
        bus.id_pc       = $urandom;
        bus.id_rs1_data = $urandom;
        bus.id_rs2_data = $urandom;
        bus.id_imm      = $urandom;
        bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
    endtask

    task automatic test_reset();
        set_instr(OP_R, 1, 2, 3);
        rst = 1'b1;
        tick(); tick();
        if (ex_vec !== '0) begin errors++; $display("FAIL reset_ex: got %0h expected 0", ex_vec); end
        checks++;
        if (bus.bubble_count !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.bubble_count); end
        checks++;
        if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.hazard_stall); end
        checks++;
        rst = 1'b0;
    endtask

    task automatic test_pass_through();
        logic [VW-1:0] want;
        set_instr(OP_R, 1, 2, 3);
        bus.id_reg_write = 1'b1;
        bus.id_alu_op    = ALU_OP_ADD;
        want = id_vec();
        #1;
        if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL pass_stall: got %b expected 0", bus.hazard_stall); end
        checks++;
        tick();
        if (bus.ex_rd !== 5'd3 || bus.ex_reg_write !== 1'b1 || bus.ex_alu_op !== 2'b00) begin
            errors++;
            $display("FAIL pass_fields: got rd=%0d rw=%b op=%b expected rd=3 rw=1 op=00",
                     bus.ex_rd, bus.ex_reg_write, bus.ex_alu_op);
        end
        checks++;
        if (ex_vec !== want) begin errors++; $display("FAIL pass_vec: got %0h expected %0h", ex_vec, want); end
        checks++;
    endtask

    task automatic test_load_use();
        set_instr(OP_LOAD, 1, 1, 5);
        tick();
        set_instr(OP_R, 5, 7, 6);
        #1;
        if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", bus.hazard_stall); end
        checks++;
        tick();
        if (bus.ex_valid !== 1'b0 || bus.bubble_count !== 4'd1) begin
            errors++;
            $display("FAIL lu_bubble: got valid=%b cnt=%0d expected valid=0 cnt=1", bus.ex_valid, bus.bubble_count);
        end
        checks++;
        if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b expected 0", bus.hazard_stall); end
        checks++;
        tick();
        if (bus.ex_rd !== 5'd6 || bus.ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL lu_advance: got rd=%0d valid=%b expected rd=6 valid=1", bus.ex_rd, bus.ex_valid);
        end
        checks++;
    endtask

    task automatic test_false_dep();
        set_instr(OP_LOAD, 2, 2, 5);
        tick();
        set_instr(OP_I, 1, 5, 6);
        #1;
        if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL fd_addi_rs2: got %b expected 0", bus.hazard_stall); end
        checks++;
        tick();
        set_instr(OP_LOAD, 3, 3, 0);
        tick();
        set_instr(OP_R, 0, 0, 4);
        #1;
        if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL fd_rd_x0: got %b expected 0", bus.hazard_stall); end
        checks++;
        tick();
        set_instr(OP_LOAD, 3, 3, 9);
        tick();
        set_instr(OP_LUI, 9, 9, 1);
        #1;
        if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL fd_lui: got %b expected 0", bus.hazard_stall); end
        checks++;
        tick();
    endtask

    task automatic test_flush_priority();
        int c0;
        set_instr(OP_LOAD, 1, 1, 5);
        tick();
        set_instr(OP_R, 5, 5, 6);
        bus.flush = 1'b1;
        c0 = m_cnt;
        #1;
        if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL fl_stall: got %b expected 0", bus.hazard_stall); end
        checks++;
        tick();
        if (bus.ex_valid !== 1'b0 || int'(bus.bubble_count) !== c0 + 1) begin
            errors++;
            $display("FAIL fl_bubble: got valid=%b cnt=%0d expected valid=0 cnt=%0d",
                     bus.ex_valid, bus.bubble_count, c0 + 1);
        end
        checks++;
        bus.flush = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [6:0] op;
            case ($urandom_range(0, 8))
                0, 1, 2: op = OP_LOAD;
                3: op = OP_R;      4: op = OP_STORE;  5: op = OP_BRANCH;
                6: op = OP_LUI;    7: op = OP_JAL;    default: op = OP_I;
            endcase
            set_instr(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            bus.id_valid = ($urandom_range(0, 9) != 0);
            bus.flush    = ($urandom_range(0, 9) == 0);
            #1;
            if (bus.hazard_stall !== exp_stall()) begin
                errors++;
                $display("FAIL rnd_stall[%0d]: got %b expected %b", i, bus.hazard_stall, exp_stall());
            end
            checks++;
            tick();
            if (ex_vec !== m_vec) begin errors++; $display("FAIL rnd_ex[%0d]: got %0h expected %0h", i, ex_vec, m_vec); end
            checks++;
            if (int'(bus.bubble_count) !== m_cnt) begin
                errors++;
                $display("FAIL rnd_cnt[%0d]: got %0d expected %0d", i, bus.bubble_count, m_cnt);
            end
            checks++;
        end
        bus.flush = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        set_instr(OP_LOAD, 1, 1, 7);
        tick();
        set_instr(OP_STORE, 1, 7, 0);
        #1;
        if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL rms_pre: got %b expected 1", bus.hazard_stall); end
        checks++;
        rst = 1'b1;
        tick();
        if (ex_vec !== '0 || bus.hazard_stall !== 1'b0 || bus.bubble_count !== 4'd0) begin
            errors++;
            $display("FAIL rms_post: got ex=%0h stall=%b cnt=%0d expected ex=0 stall=0 cnt=0",
                     ex_vec, bus.hazard_stall, bus.bubble_count);
        end
        checks++;
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        bus.flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13 && bus.bubble_count !== 4'd14) begin
                errors++;
                $display("FAIL sat_ramp: got %0d expected 14", bus.bubble_count);
            end
            if (i == 13) checks++;
        end
        if (bus.bubble_count !== 4'd15) begin errors++; $display("FAIL sat_top: got %0d expected 15", bus.bubble_count); end
        checks++;
        bus.flush    = 1'b0;
        bus.id_valid = 1'b0;
        tick();
        if (bus.bubble_count !== 4'd15 || bus.ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL sat_hold: got cnt=%0d valid=%b expected cnt=15 valid=0", bus.bubble_count, bus.ex_valid);
        end
        checks++;
    endtask

    initial begin
        bus.flush = 1'b0;
        m_vec = '0; m_ld = 0; m_rd = '0; m_cnt = 0;
        test_reset();
        test_pass_through();
        test_load_use();
        test_false_dep();
        test_flush_priority();
        test_random();
        test_reset_mid_stall();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
